partial_mixer: RTL and testbench

- Downstream consumer of the bank of sin_gen oscillators. Sums N_PARTIALS partial samples, each scaled by its own amplitude gain, into one mono sample.
- One multiply-accumulate (MAC) per cycle, time-multiplexed.
- Triggered by the same sample-rate strobe that drives get_next_sample on the oscillators.
- Output feeds the audio output stage (PWM/I2S serializer).

---
 rtl/partial_mixer.sv | 174 +++++++++++++++++
 tb/tb_partial_mixer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/partial_mixer.sv
// -----------------------------------------------------------------------------
// partial_mixer
//   Sums N_PARTIALS oscillator partials into one mono sample. Each partial is
//   scaled by its own unsigned 16-bit gain. One multiply-accumulate is done per
//   cycle. A mix starts on sample_tick and its result is presented N_PARTIALS+1
//   cycles later.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset (aborts any mix in progress)
//   sample_tick  one-cycle strobe that starts a mix (ignored while busy)
//   samples      packed signed partial samples, partial k at [16k+15:16k]
//   gains        packed unsigned gains, partial k at [16k+15:16k]
//   mix_out      saturated signed mix in [-32767, +32767], held between mixes
//   mix_valid    one-cycle pulse when mix_out has just been updated
//   busy         high while a mix is in progress
//   overrun      sticky flag: a tick arrived while busy (cleared by rst only)
// -----------------------------------------------------------------------------
module partial_mixer #(
  parameter int N_PARTIALS = 8,
  parameter int OUT_SHIFT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_tick,
  input  logic [16*N_PARTIALS-1:0]  samples,
  input  logic [16*N_PARTIALS-1:0]  gains,
  output logic [15:0]               mix_out,
  output logic                      mix_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int IDX_W = (N_PARTIALS > 1) ? $clog2(N_PARTIALS) : 1;
  // Widened by clog2(N) bits so that the sum of N full-scale products fits.
  localparam int ACC_W = 33 + $clog2(N_PARTIALS);
  localparam int SHIFT = 16 + OUT_SHIFT;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_PARTIALS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [16*N_PARTIALS-1:0]   samples_q, samples_d;
  logic [16*N_PARTIALS-1:0]   gains_q, gains_d;
  logic [15:0]                mix_out_q, mix_out_d;
  logic                       mix_valid_q, mix_valid_d;
  logic                       overrun_q, overrun_d;

  // Unpacked views of the latched operands so the MAC can select by index.
  logic signed [15:0] sample_arr [N_PARTIALS];
  logic        [15:0] gain_arr   [N_PARTIALS];

  generate
    for (genvar gi = 0; gi < N_PARTIALS; gi++) begin : g_unpack
      assign sample_arr[gi] = samples_q[16*gi +: 16];
      assign gain_arr[gi]   = gains_q[16*gi +: 16];
    end
  endgenerate

  logic signed [15:0]      cur_sample;
  logic        [15:0]      cur_gain;
  logic signed [32:0]      prod;
  logic signed [ACC_W-1:0] shifted;
  logic        [15:0]      sat_val;

  always_comb begin
    cur_sample = sample_arr[idx_q];
    cur_gain   = gain_arr[idx_q];
    // Gain is zero-extended to 17 bits so it stays non-negative as a signed operand.
    prod       = 33'(cur_sample) * $signed({17'd0, cur_gain});
    shifted    = acc_q >>> SHIFT;
    // Clamp symmetrically; 0x8000 is never produced.
    if (shifted > SAT_MAX) begin
      sat_val = 16'h7FFF;
    end else if (shifted < SAT_MIN) begin
      sat_val = 16'h8001;
    end else begin
      sat_val = shifted[15:0];
    end
  end

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (sample_tick)       state_d = ST_MAC;
      ST_MAC:  if (idx_q == LAST_IDX) state_d = ST_OUT;
      ST_OUT:                         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    samples_d   = samples_q;
    gains_d     = gains_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    // A tick while a mix is in flight (OUT included) is dropped but remembered.
    overrun_d   = overrun_q | (sample_tick & busy);

    unique case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          samples_d = samples;
          gains_d   = gains;
          acc_d     = '0;
          idx_d     = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + IDX_W'(1);
      end
      ST_OUT: begin
        mix_out_d   = sat_val;
        mix_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // Operand latches need no reset: they are always loaded before being used.
  always_ff @(posedge clk) begin
    samples_q <= samples_d;
    gains_q   <= gains_d;
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_partial_mixer.sv
// -----------------------------------------------------------------------------
// tb_partial_mixer
//   Directed and randomized checks of partial_mixer. Two instances share the
//   stimulus: the default configuration and one with OUT_SHIFT=0, so that
//   saturation can be exercised. Expected mixes come from an integer
//   sum-of-products reference model.
// -----------------------------------------------------------------------------
module tb_partial_mixer;

  localparam int NP = 8;
  localparam int W  = 16 * NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic [W-1:0]  samples = '0;
  logic [W-1:0]  gains = '0;

  logic [15:0]   mix_out_def, mix_out_s0;
  logic          mix_valid_def, mix_valid_s0;
  logic          busy_def, busy_s0;
  logic          overrun_def, overrun_s0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  partial_mixer #(.N_PARTIALS(NP), .OUT_SHIFT(3)) dut_def (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .samples(samples), .gains(gains),
    .mix_out(mix_out_def), .mix_valid(mix_valid_def),
    .busy(busy_def), .overrun(overrun_def)
  );

  partial_mixer #(.N_PARTIALS(NP), .OUT_SHIFT(0)) dut_s0 (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .samples(samples), .gains(gains),
    .mix_out(mix_out_s0), .mix_valid(mix_valid_s0),
    .busy(busy_s0), .overrun(overrun_s0)
  );

  // Reference: exact integer sum of sample*gain, floor-divided by 2^(16+shift),
  // then clamped to the symmetric 16-bit range.
  function automatic logic [15:0] model(input logic [W-1:0] s, input logic [W-1:0] g,
                                        input int sh);
    longint acc;
    logic [15:0] sk, gk;
    acc = 0;
    for (int k = 0; k < NP; k++) begin
      sk = s[16*k +: 16];
      gk = g[16*k +: 16];
      acc += longint'($signed(sk)) * longint'(int'(gk));
    end
    acc = acc >>> (16 + sh);
    if (acc > 32767)  acc = 32767;
    if (acc < -32767) acc = -32767;
    return acc[15:0];
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int k = 0; k < NP; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Run one mix: tick at edge E, inputs scrambled right after E, optional
  // second (illegal) tick at edge E+second_at. Returns right after the edge
  // that registered mix_valid, so a tick set next lands at E+NP+2.
  task automatic do_mix(input string tag, input logic [W-1:0] s, input logic [W-1:0] g,
                        input logic [15:0] exp_def, input logic [15:0] exp_s0,
                        input int second_at, input bit check_drop);
    bit got;
    samples     = s;
    gains       = g;
    sample_tick = 1'b1;
    step();                     // edge E
    sample_tick = 1'b0;
    samples     = rand_vec();
    gains       = rand_vec();
    got         = 1'b0;
    for (int k = 1; k <= 30 && !got; k++) begin
      sample_tick = (k == second_at);
      step();                   // edge E+k
      if (mix_valid_def) begin
        got = 1'b1;
        chk({tag, " latency"}, k, NP + 1);
        chk({tag, " mix_out"}, mix_out_def, exp_def);
        chk({tag, " mix_out_s0"}, mix_out_s0, exp_s0);
        chk({tag, " valid_s0"}, mix_valid_s0, 1);
        chk({tag, " busy_at_valid"}, busy_def, 0);
      end else if (k <= NP) begin
        chk({tag, " busy"}, busy_def, 1);
      end
      if (second_at > 0 && k >= second_at + 1) chk({tag, " overrun"}, overrun_def, 1);
    end
    sample_tick = 1'b0;
    chk({tag, " valid_seen"}, got, 1);
    $display("mix %s: out=0x%04h out_s0=0x%04h overrun=%0b", tag, mix_out_def, mix_out_s0,
             overrun_def);
    if (check_drop) begin
      step();
      chk({tag, " valid_drop"}, mix_valid_def, 0);
      chk({tag, " busy_idle"}, busy_def, 0);
    end
  endtask

  initial begin
    logic [W-1:0] s, g;

    // Reset held for two cycles.
    rst = 1'b1;
    step();
    step();
    chk("reset mix_out", mix_out_def, 16'h0000);
    chk("reset mix_valid", mix_valid_def, 0);
    chk("reset busy", busy_def, 0);
    chk("reset overrun", overrun_def, 0);
    rst = 1'b0;
    step();

    // Single partial at full scale.
    s = '0; g = '0;
    s[15:0] = 16'h7FFF; g[15:0] = 16'hFFFF;
    do_mix("single", s, g, 16'h0FFF, model(s, g, 0), 0, 1'b1);

    // All partials full scale: just fits by default, saturates with no shift.
    for (int k = 0; k < NP; k++) begin
      s[16*k +: 16] = 16'h7FFF;
      g[16*k +: 16] = 16'hFFFF;
    end
    do_mix("all_max", s, g, 16'h7FFE, 16'h7FFF, 0, 1'b1);

    for (int k = 0; k < NP; k++) s[16*k +: 16] = 16'h8001;
    do_mix("all_min", s, g, model(s, g, 3), 16'h8001, 0, 1'b1);

    s = rand_vec(); g = '0;
    do_mix("zero_gain", s, g, 16'h0000, 16'h0000, 0, 1'b1);

    // Overrun: second tick during MAC, then a tick right at minimum spacing.
    s = rand_vec(); g = rand_vec();
    do_mix("overrun", s, g, model(s, g, 3), model(s, g, 0), 3, 1'b0);
    s = rand_vec(); g = rand_vec();
    do_mix("after_overrun", s, g, model(s, g, 3), model(s, g, 0), 0, 1'b1);
    chk("overrun sticky", overrun_def, 1);

    // Random mixes; gains attenuated randomly so outputs span the range.
    for (int n = 0; n < 10; n++) begin
      s = rand_vec();
      g = rand_vec();
      for (int k = 0; k < NP; k++) g[16*k +: 16] = g[16*k +: 16] >> $urandom_range(0, 6);
      do_mix("random", s, g, model(s, g, 3), model(s, g, 0), 0, (n % 2) == 1);
    end

    // Latching + back-to-back.
    s = '0; g = '0;
    s[15:0] = 16'h4000; g[15:0] = 16'h8000;
    do_mix("latch", s, g, 16'h0400, model(s, g, 0), 0, 1'b0);
    s = rand_vec(); g = rand_vec();
    do_mix("back2back", s, g, model(s, g, 3), model(s, g, 0), 0, 1'b1);

    // Reset in the middle of a mix.
    samples = rand_vec(); gains = rand_vec();
    sample_tick = 1'b1;
    step();                     // E
    sample_tick = 1'b0;
    step(); step(); step();     // E+3
    rst = 1'b1;
    step();                     // E+4
    chk("midrst busy", busy_def, 0);
    chk("midrst mix_valid", mix_valid_def, 0);
    chk("midrst mix_out", mix_out_def, 16'h0000);
    chk("midrst overrun", overrun_def, 0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("midrst no_valid", mix_valid_def, 0);
    end
    $display("mix midrst: out=0x%04h busy=%0b overrun=%0b", mix_out_def, busy_def, overrun_def);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
